// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg -- shared state encoding, port IDs and watchdog default. Rev 1.0
`default_nettype none

package sram_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GNT_D = 2'd1;
  localparam state_t ST_GNT_I = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_wait_timer.sv
// sram_wait_timer -- clearable saturating cycle counter, expires at TIMEOUT_CYCLES-1. Rev 1.0
`default_nettype none

module sram_wait_timer
  import sram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// sram_arbiter -- two-port round-robin front end for the shared SRAM controller. Rev 1.0
`default_nettype none

module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINE_W         = 64,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_r_en,
  input  logic              d_w_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              i_r_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              d_ack,
  output logic              i_ack,
  output logic [LINE_W-1:0] rdata,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic              busy,
  output logic              timeout_err
);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                port_q, port_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic w_d_req;
  logic w_tie;
  logic w_grant_i;
  logic w_in_grant;
  logic w_expired;

  assign w_d_req    = d_r_en || d_w_en;
  assign w_tie      = w_d_req && i_r_en;
  assign w_grant_i  = w_tie ? (last_q == PORT_D) : i_r_en;
  assign w_in_grant = (state_q == ST_GNT_D) || (state_q == ST_GNT_I);

  sram_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!w_in_grant),
    .en_i     (w_in_grant),
    .expired_o(w_expired)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_d_req || i_r_en) begin
          port_d  = w_grant_i ? PORT_I : PORT_D;
          state_d = w_grant_i ? ST_GNT_I : ST_GNT_D;
          // A simultaneous read+write on the data port is a write.
          write_d = !w_grant_i && d_w_en;
          addr_d  = w_grant_i ? i_addr : d_addr;
          if (!w_grant_i) begin
            wdata_d = d_wdata;
          end
          if (w_tie) begin
            last_d = port_d;
          end
        end
      end
      ST_GNT_D, ST_GNT_I: begin
        if (sram_ready) begin
          rdata_d = sram_rdata;
          state_d = ST_RESP;
        end else if (w_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= PORT_I;
      port_q  <= PORT_D;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign sram_r_en   = w_in_grant && !write_q;
  assign sram_w_en   = w_in_grant && write_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;
  assign d_ack       = (state_q == ST_RESP) && (port_q == PORT_D);
  assign i_ack       = (state_q == ST_RESP) && (port_q == PORT_I);
  assign rdata       = rdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- randomized scoreboard bench for sram_arbiter with a transaction-level model. Rev 1.0
`default_nettype none

module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_r_en = 1'b0, d_w_en = 1'b0, i_r_en = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0, i_addr = '0;
  logic [63:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;
  logic        d_ack, i_ack, sram_r_en, sram_w_en, busy, timeout_err;
  logic [63:0] rdata;
  logic [31:0] sram_addr, sram_wdata;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .d_r_en(d_r_en), .d_w_en(d_w_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_r_en(i_r_en), .i_addr(i_addr),
    .d_ack(d_ack), .i_ack(i_ack), .rdata(rdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct { logic port; logic w; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
  typedef struct { logic port; logic [63:0] rdata; logic err; } ack_t;

  gnt_t gq[$];
  ack_t aq[$];
  int   checks = 0;
  int   failures = 0;

  // Transaction-level model: who is served, for how long, and what comes back.
  int          m_state = 0;
  int          m_cnt = 0;
  int          m_L = 0;
  logic        m_port = PORT_D;
  logic        m_last = PORT_I;
  logic        m_err = 1'b0;
  logic        d_pend = 1'b0, i_pend = 1'b0;
  bit          gen_en = 1'b0;
  int          force_L = 0;
  bit          force_data_v = 1'b0;
  logic [63:0] force_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue_random();
    int k;
    if (gen_en) begin
      if (!d_pend && $urandom_range(0, 99) < 40) begin
        k       = int'($urandom_range(0, 2));
        d_pend  = 1'b1;
        d_r_en  = (k != 1);
        d_w_en  = (k != 0);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if (!i_pend && $urandom_range(0, 99) < 40) begin
        i_pend = 1'b1;
        i_r_en = 1'b1;
        i_addr = $urandom;
      end
    end
  endtask

  task automatic step();
    gnt_t g;
    ack_t a;
    sram_ready = 1'b0;
    sram_rdata = {$urandom, $urandom};
    case (m_state)
      0: begin
        issue_random();
        if (d_r_en || d_w_en || i_r_en) begin
          if ((d_r_en || d_w_en) && i_r_en) begin
            m_port = (m_last == PORT_D) ? PORT_I : PORT_D;
            m_last = m_port;
          end else begin
            m_port = i_r_en ? PORT_I : PORT_D;
          end
          g.port  = m_port;
          g.w     = (m_port == PORT_D) && d_w_en;
          g.addr  = (m_port == PORT_D) ? d_addr : i_addr;
          g.wdata = d_wdata;
          gq.push_back(g);
          m_L     = (force_L != 0) ? force_L : int'($urandom_range(1, T + 2));
          m_cnt   = 0;
          m_state = 1;
        end else begin
          sram_ready = 1'($urandom_range(0, 1));
        end
      end
      1: begin
        m_cnt++;
        if (m_cnt == 1 && $urandom_range(0, 3) == 0) begin
          if (m_port == PORT_D) begin
            d_addr  = $urandom;
            d_wdata = $urandom;
            if ($urandom_range(0, 1) == 1) begin
              d_r_en = 1'b0;
              d_w_en = 1'b0;
            end
          end else begin
            i_addr = $urandom;
            if ($urandom_range(0, 1) == 1) i_r_en = 1'b0;
          end
        end
        issue_random();
        if (m_cnt == m_L && m_L <= T) begin
          sram_ready = 1'b1;
          if (force_data_v) sram_rdata = force_data;
          a.port = m_port; a.rdata = sram_rdata; a.err = m_err;
          aq.push_back(a);
          m_state = 2;
        end else if (m_cnt == T) begin
          m_err  = 1'b1;
          a.port = m_port; a.rdata = 64'd0; a.err = 1'b1;
          aq.push_back(a);
          m_state = 2;
        end
      end
      default: begin
        if (m_port == PORT_D) begin
          d_pend = 1'b0; d_r_en = 1'b0; d_w_en = 1'b0;
        end else begin
          i_pend = 1'b0; i_r_en = 1'b0;
        end
        sram_ready = 1'($urandom_range(0, 1));
        issue_random();
        m_state = 0;
      end
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d_ack"}, 64'(d_ack), 64'd0);
    chk({tag, "_i_ack"}, 64'(i_ack), 64'd0);
    chk({tag, "_r_en"}, 64'(sram_r_en), 64'd0);
    chk({tag, "_w_en"}, 64'(sram_w_en), 64'd0);
    chk({tag, "_addr"}, 64'(sram_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(sram_wdata), 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(timeout_err), 64'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or an ack.
  gnt_t cur;
  ack_t got;
  bit   cur_v = 1'b0;
  bit   prev_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cur_v   = 1'b0;
        prev_en = 1'b0;
      end else begin
        chk("ack_exclusive", 64'(d_ack & i_ack), 64'd0);
        chk("ack_with_enable", 64'((d_ack | i_ack) & (sram_r_en | sram_w_en)), 64'd0);
        if (sram_r_en || sram_w_en) begin
          if (!prev_en) begin
            if (gq.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_grant actual=enable required=idle");
              cur_v = 1'b0;
            end else begin
              cur   = gq.pop_front();
              cur_v = 1'b1;
            end
          end
          if (cur_v) begin
            chk("gnt_w_en", 64'(sram_w_en), 64'(cur.w));
            chk("gnt_r_en", 64'(sram_r_en), 64'(!cur.w));
            chk("gnt_addr", 64'(sram_addr), 64'(cur.addr));
            if (cur.w) chk("gnt_wdata", 64'(sram_wdata), 64'(cur.wdata));
            chk("gnt_busy", 64'(busy), 64'd1);
          end
        end
        prev_en = sram_r_en || sram_w_en;
        if (d_ack || i_ack) begin
          if (aq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=ack required=none");
          end else begin
            got = aq.pop_front();
            chk("ack_port", 64'(i_ack), 64'(got.port));
            chk("ack_rdata", rdata, got.rdata);
            chk("ack_err", 64'(timeout_err), 64'(got.err));
            chk("ack_busy", 64'(busy), 64'd1);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single data read with a known line.
    d_pend = 1'b1; d_r_en = 1'b1; d_addr = 32'h100;
    force_L = 4; force_data_v = 1'b1; force_data = 64'hDEADBEEF_CAFEF00D;
    run(8);
    force_data_v = 1'b0;

    // Data write.
    d_pend = 1'b1; d_w_en = 1'b1; d_addr = 32'h204; d_wdata = 32'h12345678;
    force_L = 3;
    run(8);

    // Instruction read that never gets sram_ready.
    i_pend = 1'b1; i_r_en = 1'b1; i_addr = 32'h3000;
    force_L = T + 5;
    run(T + 4);

    // Tie fairness: both ports pending for four transactions.
    force_L = 1;
    repeat (2) begin
      d_pend = 1'b1; d_r_en = 1'b1; d_addr = $urandom;
      i_pend = 1'b1; i_r_en = 1'b1; i_addr = $urandom;
      run(8);
    end

    // Reset two cycles into a data grant.
    d_pend = 1'b1; d_r_en = 1'b1; d_addr = 32'h440;
    force_L = 100;
    run(2);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    gq.delete();
    aq.delete();
    m_state = 0; m_last = PORT_I; m_err = 1'b0;
    d_pend = 1'b0; i_pend = 1'b0;
    d_r_en = 1'b0; d_w_en = 1'b0; i_r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    d_pend = 1'b1; d_r_en = 1'b1; d_addr = 32'h480;
    force_L = 2;
    run(6);

    // Randomized traffic, then drain.
    force_L = 0;
    gen_en  = 1'b1;
    run(3000);
    gen_en = 1'b0;
    run(T + 12);

    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("ack_queue_drained", 64'(aq.size()), 64'd0);
    chk("final_err_sticky", 64'(timeout_err), 64'(m_err));
    chk("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
